// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: a two-stage PC pipeline (F0 candidate, F1 presented)
// with a direct-mapped BTB for predicted targets. It drives the external gshare
// predictor with pred_pc and takes its taken/not-taken answer one cycle later.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BTB_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pred_pc,
  input  logic        pred_taken,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_pc,
  output logic        fetch_pred_taken,
  output logic [31:0] fetch_pred_target,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        btb_update_valid,
  input  logic [31:0] btb_update_pc,
  input  logic [31:0] btb_update_target
);

  localparam int unsigned BTB_ENTRIES = 1 << BTB_IDX_W;
  localparam int unsigned TAG_W       = 32 - BTB_IDX_W - 2;
  localparam int unsigned TGT_W       = 30;
  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  // Pipeline state
  logic [31:0] pc_f0_q, pc_f0_d;
  logic [31:0] f1_pc_q, f1_pc_d;
  logic        f1_valid_q, f1_valid_d;

  // BTB storage; only the valid bits need a reset
  logic [BTB_ENTRIES-1:0] btb_vld_q;
  logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [TGT_W-1:0]       btb_tgt_q [BTB_ENTRIES];

  // Registered BTB read, always aligned with the PC sitting in F1
  logic             rd_vld_q;
  logic [TAG_W-1:0] rd_tag_q;
  logic [TGT_W-1:0] rd_tgt_q;

  logic                 stall;
  logic                 btb_hit;
  logic [BTB_IDX_W-1:0] rd_idx;
  logic [BTB_IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0]     upd_tag;
  logic [TAG_W-1:0]     f1_tag;
  logic                 unused_bits;

  assign stall   = f1_valid_q & ~fetch_ready;
  // While stalled the predictor and BTB keep looking at the held F1 PC
  assign pred_pc = stall ? f1_pc_q : pc_f0_q;

  assign rd_idx  = pred_pc[BTB_IDX_W+1:2];
  assign upd_idx = btb_update_pc[BTB_IDX_W+1:2];
  assign upd_tag = btb_update_pc[31:BTB_IDX_W+2];
  assign f1_tag  = f1_pc_q[31:BTB_IDX_W+2];

  // Low address bits are word-alignment only and carry no information
  assign unused_bits = ^{redirect_pc[1:0], btb_update_pc[1:0], btb_update_target[1:0]};

  assign btb_hit           = rd_vld_q & (rd_tag_q == f1_tag);
  assign fetch_valid       = f1_valid_q;
  assign fetch_pc          = f1_pc_q;
  assign fetch_pred_taken  = f1_valid_q & pred_taken & btb_hit;

  // Predicted next PC for the F1 instruction; zero when F1 is empty
  always_comb begin
    fetch_pred_target = 32'h0;
    if (f1_valid_q) begin
      if (fetch_pred_taken) begin
        fetch_pred_target = {rd_tgt_q, 2'b00};
      end else begin
        fetch_pred_target = f1_pc_q + 32'd4;
      end
    end
  end

  // Next-state: redirect > stall > predicted-taken squash > sequential advance
  always_comb begin
    pc_f0_d    = pc_f0_q;
    f1_pc_d    = f1_pc_q;
    f1_valid_d = f1_valid_q;
    if (redirect_valid) begin
      pc_f0_d    = {redirect_pc[31:2], 2'b00};
      f1_valid_d = 1'b0;
    end else if (stall) begin
      pc_f0_d    = pc_f0_q;
      f1_pc_d    = f1_pc_q;
      f1_valid_d = f1_valid_q;
    end else if (f1_valid_q && fetch_pred_taken) begin
      pc_f0_d    = fetch_pred_target;
      f1_valid_d = 1'b0;
    end else begin
      f1_pc_d    = pc_f0_q;
      f1_valid_d = 1'b1;
      pc_f0_d    = pc_f0_q + 32'd4;
    end
  end

  // Pipeline state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_f0_q    <= RESET_PC_AL;
      f1_pc_q    <= 32'h0;
      f1_valid_q <= 1'b0;
    end else begin
      pc_f0_q    <= pc_f0_d;
      f1_pc_q    <= f1_pc_d;
      f1_valid_q <= f1_valid_d;
    end
  end

  // BTB valid bits: cleared by reset, set by a resolved-taken update
  always_ff @(posedge clk) begin
    if (!rst) begin
      btb_vld_q <= '0;
    end else if (btb_update_valid) begin
      btb_vld_q[upd_idx] <= 1'b1;
    end
  end

  // BTB tag/target payload; overwrite is unconditional
  always_ff @(posedge clk) begin
    if (rst && btb_update_valid) begin
      btb_tag_q[upd_idx] <= upd_tag;
      btb_tgt_q[upd_idx] <= btb_update_target[31:2];
    end
  end

  // BTB read port; a same-cycle write to the index is seen on the next read
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_vld_q <= 1'b0;
      rd_tag_q <= '0;
      rd_tgt_q <= '0;
    end else begin
      rd_vld_q <= btb_vld_q[rd_idx];
      rd_tag_q <= btb_tag_q[rd_idx];
      rd_tgt_q <= btb_tgt_q[rd_idx];
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios with literal expectations, plus a
// per-cycle comparison against a behavioural model of the fetch stream.
module tb_fetch_pc_gen;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int NENT = 64;

  logic        clk;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        fetch_pred_taken;
  logic [31:0] fetch_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        btb_update_valid;
  logic [31:0] btb_update_pc;
  logic [31:0] btb_update_target;

  int errors = 0;
  int checks = 0;

  fetch_pc_gen #(.RESET_PC(RST_PC), .BTB_IDX_W(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .pred_pc           (pred_pc),
    .pred_taken        (pred_taken),
    .fetch_valid       (fetch_valid),
    .fetch_ready       (fetch_ready),
    .fetch_pc          (fetch_pc),
    .fetch_pred_taken  (fetch_pred_taken),
    .fetch_pred_target (fetch_pred_target),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .btb_update_valid  (btb_update_valid),
    .btb_update_pc     (btb_update_pc),
    .btb_update_target (btb_update_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // BTB modelled as "which branch PC/target was last recorded per slot"; the
  // lookup for the PC in F1 sees the table as it stood before the latest edge.
  bit          m_on = 0;
  bit [31:0]   m_pc_f0, m_f1_pc;
  bit          m_f1_valid;
  bit          bv [NENT];
  bit [31:0]   bpc[NENT];
  bit [31:0]   btg[NENT];
  bit          pv [NENT];
  bit [31:0]   ppc[NENT];
  bit [31:0]   ptg[NENT];

  function automatic int slot(input bit [31:0] pc);
    return int'((pc / 4) % NENT);
  endfunction

  function automatic bit m_hit(input bit [31:0] pc);
    int s = slot(pc);
    return pv[s] && ((ppc[s] / 256) == (pc / 256));
  endfunction

  function automatic bit m_taken(input bit p_taken);
    return m_f1_valid && p_taken && m_hit(m_f1_pc);
  endfunction

  function automatic bit [31:0] m_target(input bit tk);
    if (!m_f1_valid) return 32'h0;
    if (tk) return ptg[slot(m_f1_pc)];
    return m_f1_pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    bit tk;
    bit [31:0] tg;
    if (!rst) begin
      m_pc_f0    = RST_PC & 32'hFFFF_FFFC;
      m_f1_pc    = 32'h0;
      m_f1_valid = 1'b0;
      for (int i = 0; i < NENT; i++) begin bv[i] = 0; pv[i] = 0; end
      m_on = 1;
    end else if (m_on) begin
      tk = m_taken(pred_taken);
      tg = m_target(tk);
      pv = bv; ppc = bpc; ptg = btg;
      if (btb_update_valid) begin
        bv[slot(btb_update_pc)]  = 1;
        bpc[slot(btb_update_pc)] = btb_update_pc;
        btg[slot(btb_update_pc)] = btb_update_target & 32'hFFFF_FFFC;
      end
      if (redirect_valid) begin
        m_pc_f0    = redirect_pc & 32'hFFFF_FFFC;
        m_f1_valid = 0;
      end else if (m_f1_valid && !fetch_ready) begin
        // instruction queue full: everything holds
      end else if (tk) begin
        m_pc_f0    = tg;
        m_f1_valid = 0;
      end else begin
        m_f1_pc    = m_pc_f0;
        m_f1_valid = 1;
        m_pc_f0    = m_pc_f0 + 32'd4;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    bit tk;
    if (m_on) begin
      tk = m_taken(pred_taken);
      chk("m_pred_pc", pred_pc, (m_f1_valid && !fetch_ready) ? m_f1_pc : m_pc_f0);
      chk("m_fetch_valid", 32'(fetch_valid), 32'(m_f1_valid));
      if (m_f1_valid) chk("m_fetch_pc", fetch_pc, m_f1_pc);
      chk("m_pred_taken", 32'(fetch_pred_taken), 32'(tk));
      chk("m_pred_target", fetch_pred_target, m_target(tk));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 0; pred_taken = 0; fetch_ready = 1;
    redirect_valid = 0; redirect_pc = 0;
    btb_update_valid = 0; btb_update_pc = 0; btb_update_target = 0;

    tick(); tick(); #2;
    chk("rst_valid", 32'(fetch_valid), 0);
    chk("rst_pc", fetch_pc, 0);
    chk("rst_pred_pc", pred_pc, RST_PC);
    chk("rst_taken", 32'(fetch_pred_taken), 0);
    chk("rst_target", fetch_pred_target, 0);
    rst = 1;

    // sequential fetch from reset
    for (int k = 0; k < 4; k++) begin
      tick(); #2;
      chk("t1_pc", fetch_pc, 32'(4 * k));
      chk("t1_valid", 32'(fetch_valid), 1);
      chk("t1_taken", 32'(fetch_pred_taken), 0);
      chk("t1_target", fetch_pred_target, 32'(4 * k + 4));
    end

    // BTB entry 0x8 -> 0x40 written alongside a redirect to 0
    btb_update_valid = 1; btb_update_pc = 32'h8; btb_update_target = 32'h40;
    redirect_valid = 1; redirect_pc = 32'h0;
    tick();
    btb_update_valid = 0; redirect_valid = 0; pred_taken = 1; #2;
    chk("t2_flush_valid", 32'(fetch_valid), 0);
    chk("t2_flush_taken", 32'(fetch_pred_taken), 0);
    chk("t2_flush_pred_pc", pred_pc, 32'h0);
    tick(); #2; chk("t2_pc0", fetch_pc, 32'h0); chk("t2_tk0", 32'(fetch_pred_taken), 0);
    tick(); #2; chk("t2_pc4", fetch_pc, 32'h4);
    tick(); #2;
    chk("t2_pc8", fetch_pc, 32'h8);
    chk("t2_tk8", 32'(fetch_pred_taken), 1);
    chk("t2_tgt8", fetch_pred_target, 32'h40);
    tick(); #2;
    chk("t2_bubble", 32'(fetch_valid), 0);
    chk("t2_bubble_pred_pc", pred_pc, 32'h40);
    tick(); #2; chk("t2_pc40", fetch_pc, 32'h40); chk("t2_tgt40", fetch_pred_target, 32'h44);
    tick(); #2; chk("t2_pc44", fetch_pc, 32'h44);

    // BTB hit but predictor says not taken
    redirect_valid = 1; redirect_pc = 32'h8; pred_taken = 0;
    tick(); redirect_valid = 0; #2;
    chk("t3_flush_valid", 32'(fetch_valid), 0);
    tick(); #2;
    chk("t3_pc8", fetch_pc, 32'h8);
    chk("t3_tk8", 32'(fetch_pred_taken), 0);
    chk("t3_tgt8", fetch_pred_target, 32'hC);
    tick(); #2;
    chk("t3_pcC", fetch_pc, 32'hC);
    chk("t3_validC", 32'(fetch_valid), 1);

    // three-cycle stall at 0x10
    tick(); #2; chk("t4_pc10", fetch_pc, 32'h10);
    fetch_ready = 0; #1;
    chk("t4_stall_pred_pc", pred_pc, 32'h10);
    for (int k = 0; k < 3; k++) begin
      tick(); #2;
      chk("t4_hold_pc", fetch_pc, 32'h10);
      chk("t4_hold_valid", 32'(fetch_valid), 1);
      chk("t4_hold_pred_pc", pred_pc, 32'h10);
    end
    fetch_ready = 1; #1;
    chk("t4_release_pc", fetch_pc, 32'h10);
    chk("t4_release_pred_pc", pred_pc, 32'h14);
    tick(); #2; chk("t4_pc14", fetch_pc, 32'h14);

    // redirect to an unaligned PC while stalled
    fetch_ready = 0; redirect_valid = 1; redirect_pc = 32'h103;
    tick(); redirect_valid = 0; #2;
    chk("t5_flush_valid", 32'(fetch_valid), 0);
    chk("t5_pred_pc", pred_pc, 32'h100);
    tick(); #2;
    chk("t5_pc100", fetch_pc, 32'h100);
    chk("t5_valid100", 32'(fetch_valid), 1);

    // same-cycle write/read of slot 2, then reset during a stall
    fetch_ready = 1; redirect_valid = 1; redirect_pc = 32'h108; pred_taken = 1;
    tick(); redirect_valid = 0;
    btb_update_valid = 1; btb_update_pc = 32'h108; btb_update_target = 32'h201; #2;
    chk("t6_pred_pc", pred_pc, 32'h108);
    tick(); btb_update_valid = 0; fetch_ready = 0; #2;
    chk("t6_old_pc", fetch_pc, 32'h108);
    chk("t6_old_taken", 32'(fetch_pred_taken), 0);
    chk("t6_old_target", fetch_pred_target, 32'h10C);
    tick(); #2;
    chk("t6_new_pc", fetch_pc, 32'h108);
    chk("t6_new_taken", 32'(fetch_pred_taken), 1);
    chk("t6_new_target", fetch_pred_target, 32'h200);
    rst = 0; btb_update_valid = 1; btb_update_pc = 32'h8; btb_update_target = 32'h80;
    tick(); #2;
    chk("t6_rst_valid", 32'(fetch_valid), 0);
    chk("t6_rst_pc", fetch_pc, 32'h0);
    chk("t6_rst_pred_pc", pred_pc, RST_PC);
    chk("t6_rst_target", fetch_pred_target, 32'h0);
    rst = 1; btb_update_valid = 0; fetch_ready = 1;
    tick(); #2; chk("t6_pc0", fetch_pc, 32'h0);
    tick(); #2; chk("t6_pc4", fetch_pc, 32'h4);
    tick(); #2;
    chk("t6_pc8", fetch_pc, 32'h8);
    chk("t6_empty_taken", 32'(fetch_pred_taken), 0);
    chk("t6_empty_target", fetch_pred_target, 32'hC);

    // PC+4 wraps at the top of the address space
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
    tick(); redirect_valid = 0; #2;
    chk("wrap_pred_pc", pred_pc, 32'hFFFF_FFFC);
    tick(); #2;
    chk("wrap_pc", fetch_pc, 32'hFFFF_FFFC);
    chk("wrap_target", fetch_pred_target, 32'h0);
    tick(); #2;
    chk("wrap_next_pc", fetch_pc, 32'h0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
